// File: rtl/register_bank_pkg.sv
// Shared defaults and helpers for the register bank: parameter defaults,
// address-width helper and the read-source selector type.
package register_bank_pkg;

   localparam int DEF_WIDTH    = 7;
   localparam int DEF_DEPTH    = 8;
   localparam bit DEF_ZERO_REG = 1'b1;
   localparam bit DEF_BYPASS   = 1'b1;

   typedef enum logic [1:0] {
      SRC_ZERO   = 2'd0,
      SRC_ENTRY  = 2'd1,
      SRC_BYPASS = 2'd2
   } read_src_e;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/register_bank_if.sv
// Write/reserve/read-address bundle of the register bank plus the scoreboard
// busy flags. The tri-state data buses stay plain ports on the top.
interface register_bank_if #(
   parameter int WIDTH = 7,
   parameter int AW    = 3
);
   logic             ie;
   logic             write_ctrl;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] in;
   logic             rsv;
   logic [AW-1:0]    rsv_addr;
   logic [AW-1:0]    raddrA;
   logic [AW-1:0]    raddrB;
   logic             oeA;
   logic             oeB;
   logic             busyA;
   logic             busyB;

   modport master (
      output ie, write_ctrl, waddr, in, rsv, rsv_addr, raddrA, raddrB, oeA, oeB,
      input  busyA, busyB
   );

   modport slave (
      input  ie, write_ctrl, waddr, in, rsv, rsv_addr, raddrA, raddrB, oeA, oeB,
      output busyA, busyB
   );
endinterface

// File: rtl/register_bank_entry.sv
// One storage entry: data word with write enable and a pending flag whose set
// input dominates its clear input (a new producer outranks a retiring one).
module register_bank_entry #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pend_set,
   input  logic             pend_clr,
   output logic [WIDTH-1:0] data_q,
   output logic             pend_q
);

   logic [WIDTH-1:0] data_d;
   logic             pend_d;

   // next data and pending state
   always_comb begin
      data_d = data_q;
      pend_d = pend_q;
      if (we) begin
         data_d = wdata;
      end else begin
         data_d = data_q;
      end
      if (pend_set) begin
         pend_d = 1'b1;
      end else if (pend_clr) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
   end

   // state register with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!clr) begin
         data_q <= '0;
         pend_q <= 1'b0;
      end else begin
         data_q <= data_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/register_bank.sv
// Multi-entry register bank: one write port, two tri-state read ports,
// per-entry pending scoreboard, optional zero entry and write-to-read bypass.
module register_bank
   import register_bank_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter bit ZERO_REG = DEF_ZERO_REG,
   parameter bit BYPASS   = DEF_BYPASS,
   parameter int AW       = addr_width(DEPTH)
) (
   input  logic                clk,
   input  logic                clr,
   register_bank_if.slave      bus,
   output wire  [WIDTH-1:0]    outA,
   output wire  [WIDTH-1:0]    outB
);

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic                wr_en_s;
   logic [WIDTH-1:0]    entry_data_s [DEPTH];
   logic [DEPTH-1:0]    entry_pend_s;
   logic [AW-1:0]       raddr_s      [2];
   read_src_e           src_s        [2];
   logic [WIDTH-1:0]    data_s       [2];
   logic                busy_s       [2];

   assign wr_en_s    = bus.ie & bus.write_ctrl;
   assign raddr_s[0] = bus.raddrA;
   assign raddr_s[1] = bus.raddrB;

   // Entry 0 has no storage when hardwired to zero; out-of-range indices match no entry.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if (ZERO_REG && (i == 0)) begin : g_zero
         assign entry_data_s[i] = '0;
         assign entry_pend_s[i] = 1'b0;
      end else begin : g_reg
         logic we_s;
         logic set_s;
         assign we_s  = wr_en_s && (bus.waddr == AW'(i));
         assign set_s = bus.rsv && (bus.rsv_addr == AW'(i));
         register_bank_entry #(.WIDTH(WIDTH)) u_entry (
            .clk      (clk),
            .clr      (clr),
            .we       (we_s),
            .wdata    (bus.in),
            .pend_set (set_s),
            .pend_clr (we_s),
            .data_q   (entry_data_s[i]),
            .pend_q   (entry_pend_s[i])
         );
      end
   end

   // read source selection per port
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         src_s[p] = SRC_ZERO;
         if (!clr) begin
            src_s[p] = SRC_ZERO;
         end else if ({1'b0, raddr_s[p]} >= DEPTH_W) begin
            src_s[p] = SRC_ZERO;
         end else if (ZERO_REG && (raddr_s[p] == '0)) begin
            src_s[p] = SRC_ZERO;
         end else if (BYPASS && wr_en_s && (bus.waddr == raddr_s[p])) begin
            src_s[p] = SRC_BYPASS;
         end else begin
            src_s[p] = SRC_ENTRY;
         end
      end
   end

   // read data and busy per port; a bypassed entry is only busy if re-reserved now
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         data_s[p] = '0;
         busy_s[p] = 1'b0;
         case (src_s[p])
            SRC_ENTRY: begin
               data_s[p] = entry_data_s[raddr_s[p]];
               busy_s[p] = entry_pend_s[raddr_s[p]];
            end
            SRC_BYPASS: begin
               data_s[p] = bus.in;
               busy_s[p] = bus.rsv && (bus.rsv_addr == raddr_s[p]);
            end
            default: begin
               data_s[p] = '0;
               busy_s[p] = 1'b0;
            end
         endcase
      end
   end

   assign bus.busyA = busy_s[0];
   assign bus.busyB = busy_s[1];

   assign outA = bus.oeA ? data_s[0] : {WIDTH{1'bz}};
   assign outB = bus.oeB ? data_s[1] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed scenarios with literal expectations and a
// randomized run, both DUT variants (bypass on/off) checked against one array model.
module tb_register_bank;

   localparam int W  = 7;
   localparam int D  = 8;
   localparam int AW = 3;

   logic clk = 1'b0;
   logic clr;
   int   errors = 0;
   int   checks = 0;
   bit   four_state;

   logic [W-1:0] m_data [D];
   logic         m_pend [D];

   wire [W-1:0] out_a, out_b, out_a_nb, out_b_nb;

   register_bank_if #(.WIDTH(W), .AW(AW)) bif ();
   register_bank_if #(.WIDTH(W), .AW(AW)) bif_nb ();

   assign bif_nb.ie         = bif.ie;
   assign bif_nb.write_ctrl = bif.write_ctrl;
   assign bif_nb.waddr      = bif.waddr;
   assign bif_nb.in         = bif.in;
   assign bif_nb.rsv        = bif.rsv;
   assign bif_nb.rsv_addr   = bif.rsv_addr;
   assign bif_nb.raddrA     = bif.raddrA;
   assign bif_nb.raddrB     = bif.raddrB;
   assign bif_nb.oeA        = bif.oeA;
   assign bif_nb.oeB        = bif.oeB;

   register_bank #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
      .clk(clk), .clr(clr), .bus(bif.slave), .outA(out_a), .outB(out_b)
   );

   register_bank #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
      .clk(clk), .clr(clr), .bus(bif_nb.slave), .outA(out_a_nb), .outB(out_b_nb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Expected {busy, data} of a read port, straight from the bank's read rules.
   function automatic logic [W:0] exp_port(input logic [AW-1:0] ra, input bit bypass);
      logic [W:0] e;
      if (!clr) e = '0;
      else if (int'(ra) >= D) e = '0;
      else if (ra == 3'd0) e = '0;
      else if (bypass && bif.ie && bif.write_ctrl && (bif.waddr == ra))
         e = {(bif.rsv && (bif.rsv_addr == ra)), bif.in};
      else e = {m_pend[ra], m_data[ra]};
      return e;
   endfunction

   task automatic check_port(input string name, input logic [W-1:0] out, input logic oe,
                             input logic busy, input logic [W:0] e);
      logic [W-1:0] zval;
      zval = {W{1'bz}};
      chk({name, "_busy"}, {31'd0, busy}, {31'd0, e[W]});
      if (oe) chk({name, "_data"}, {25'd0, out}, {25'd0, e[W-1:0]});
      else if (four_state) chk({name, "_hiz"}, {25'd0, out}, {25'd0, zval});
   endtask

   task automatic model_update();
      if (!clr) begin
         for (int i = 0; i < D; i++) begin
            m_data[i] = '0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (bif.ie && bif.write_ctrl && int'(bif.waddr) < D && bif.waddr != 3'd0) begin
            m_data[bif.waddr] = bif.in;
            m_pend[bif.waddr] = 1'b0;
         end
         if (bif.rsv && int'(bif.rsv_addr) < D && bif.rsv_addr != 3'd0)
            m_pend[bif.rsv_addr] = 1'b1;
      end
   endtask

   // Compare both DUTs against the model, then let one clock edge happen.
   task automatic step();
      check_port("a_byp", out_a, bif.oeA, bif.busyA, exp_port(bif.raddrA, 1'b1));
      check_port("b_byp", out_b, bif.oeB, bif.busyB, exp_port(bif.raddrB, 1'b1));
      check_port("a_nb", out_a_nb, bif.oeA, bif_nb.busyA, exp_port(bif.raddrA, 1'b0));
      check_port("b_nb", out_b_nb, bif.oeB, bif_nb.busyB, exp_port(bif.raddrB, 1'b0));
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_idle();
      clr = 1'b1; bif.ie = 1'b0; bif.write_ctrl = 1'b0; bif.waddr = '0; bif.in = '0;
      bif.rsv = 1'b0; bif.rsv_addr = '0; bif.raddrA = '0; bif.raddrB = '0;
      bif.oeA = 1'b0; bif.oeB = 1'b0;
   endtask

   task automatic set_write(input logic [AW-1:0] a, input logic [W-1:0] v);
      bif.ie = 1'b1; bif.write_ctrl = 1'b1; bif.waddr = a; bif.in = v;
   endtask

   initial begin
      logic xp;
      xp = 1'bx;
      four_state = (xp === 1'bx);
      for (int i = 0; i < D; i++) begin
         m_data[i] = '0;
         m_pend[i] = 1'b0;
      end
      set_idle();
      clr = 1'b0;
      @(negedge clk); #1; step();
      #1; step();

      // reset clears everything that was written
      for (int a = 1; a < D; a++) begin
         set_idle(); set_write(AW'(a), 7'h7F); #1; step();
      end
      set_idle(); clr = 1'b0; #1; step();
      for (int a = 0; a < D; a++) begin
         set_idle(); bif.raddrA = AW'(a); bif.oeA = 1'b1; #1;
         chk("rst_out", {25'd0, out_a}, 32'h0);
         chk("rst_busy", {31'd0, bif.busyA}, 32'h0);
         step();
      end

      // write/read, tri-state, ie gating
      set_idle(); set_write(3'd3, 7'h2A); #1; step();
      set_idle(); bif.raddrA = 3'd3; bif.oeA = 1'b1; #1;
      chk("wr_read", {25'd0, out_a}, 32'h2A); step();
      set_idle(); bif.raddrA = 3'd3; #1; step();
      set_idle(); set_write(3'd3, 7'h01); bif.ie = 1'b0; #1; step();
      set_idle(); bif.raddrA = 3'd3; bif.oeA = 1'b1; #1;
      chk("ie_gate", {25'd0, out_a}, 32'h2A); step();

      // bypass vs no bypass
      set_idle(); set_write(3'd5, 7'h11); bif.raddrB = 3'd5; bif.oeB = 1'b1; #1;
      chk("byp_same", {25'd0, out_b}, 32'h11);
      chk("nobyp_old", {25'd0, out_b_nb}, 32'h00); step();
      set_idle(); bif.raddrB = 3'd5; bif.oeB = 1'b1; #1;
      chk("nobyp_next", {25'd0, out_b_nb}, 32'h11); step();

      // scoreboard
      set_idle(); bif.rsv = 1'b1; bif.rsv_addr = 3'd4; #1; step();
      set_idle(); bif.raddrA = 3'd4; #1;
      chk("rsv_busy", {31'd0, bif.busyA}, 32'h1); step();
      set_idle(); set_write(3'd4, 7'h0A); bif.raddrA = 3'd4; bif.oeA = 1'b1; #1;
      chk("wr_byp_busy", {31'd0, bif.busyA}, 32'h0);
      chk("wr_nb_busy", {31'd0, bif_nb.busyA}, 32'h1); step();
      set_idle(); bif.raddrA = 3'd4; #1;
      chk("wr_nb_busy_next", {31'd0, bif_nb.busyA}, 32'h0); step();
      set_idle(); set_write(3'd4, 7'h0B); bif.rsv = 1'b1; bif.rsv_addr = 3'd4; #1; step();
      set_idle(); bif.raddrA = 3'd4; bif.oeA = 1'b1; #1;
      chk("rsvwr_busy", {31'd0, bif.busyA}, 32'h1);
      chk("rsvwr_data", {25'd0, out_a}, 32'h0B); step();

      // zero entry
      set_idle(); set_write(3'd0, 7'h55); bif.rsv = 1'b1; bif.rsv_addr = 3'd0;
      bif.raddrA = 3'd0; bif.oeA = 1'b1; #1;
      chk("zero_same", {25'd0, out_a}, 32'h0); step();
      set_idle(); bif.raddrA = 3'd0; bif.oeA = 1'b1; #1;
      chk("zero_data", {25'd0, out_a}, 32'h0);
      chk("zero_busy", {31'd0, bif.busyA}, 32'h0); step();

      // reset beats a write on the same edge
      set_idle(); set_write(3'd2, 7'h33); bif.rsv = 1'b1; bif.rsv_addr = 3'd2; #1; step();
      set_idle(); bif.raddrA = 3'd2; bif.oeA = 1'b1; #1;
      chk("mid_pre_data", {25'd0, out_a}, 32'h33);
      chk("mid_pre_busy", {31'd0, bif.busyA}, 32'h1); step();
      set_idle(); clr = 1'b0; set_write(3'd2, 7'h44); #1; step();
      set_idle(); bif.raddrA = 3'd2; bif.oeA = 1'b1; #1;
      chk("mid_data", {25'd0, out_a}, 32'h0);
      chk("mid_busy", {31'd0, bif.busyA}, 32'h0); step();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         clr            = ($urandom_range(0, 40) != 0);
         bif.ie         = ($urandom_range(0, 3) != 0);
         bif.write_ctrl = $urandom_range(0, 1) != 0;
         bif.waddr      = AW'($urandom_range(0, D - 1));
         bif.in         = W'($urandom);
         bif.rsv        = ($urandom_range(0, 2) == 0);
         bif.rsv_addr   = AW'($urandom_range(0, D - 1));
         bif.raddrA     = ($urandom_range(0, 2) == 0) ? bif.waddr : AW'($urandom_range(0, D - 1));
         bif.raddrB     = ($urandom_range(0, 3) == 0) ? bif.raddrA : AW'($urandom_range(0, D - 1));
         bif.oeA        = ($urandom_range(0, 3) != 0);
         bif.oeB        = ($urandom_range(0, 3) != 0);
         #1;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
